qbert_jump_scheduler: RTL and testbench

Arbitrates Q*bert jump requests from two requesters, the SPI touch/accelerometer decoder and the Nios software path, and queues them in a small FIFO. Jumps are issued one at a time to the Qbert move engine (the `Qbert_Map_Color` datapath) through the `qbert_jump` / start / `done_move` handshake. The block sits in the `CLK_33` (LCD) domain between the Avalon register bank / SPI front end and the map-colour engine. It replaces direct software writes of `qbert_jump` and `nios_start_qbert`.

---
 rtl/qbert_jump_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_qbert_jump_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_jump_scheduler.sv
// Arbitrates SPI and Nios jump requests into a small FIFO and issues them one at a
// time to the Qbert move engine through the start_qbert / done_move handshake.
module qbert_jump_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1048576,
    parameter int GAP     = 2
) (
    input  logic                   CLK_33,
    input  logic                   reset,
    input  logic                   spi_req,
    input  logic [2:0]             spi_dir,
    input  logic                   nios_req,
    input  logic [2:0]             nios_dir,
    input  logic                   flush,
    input  logic                   done_move,
    output logic                   spi_ack,
    output logic                   nios_ack,
    output logic                   reject,
    output logic                   drop,
    output logic [2:0]             qbert_jump,
    output logic                   start_qbert,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_ONE  = TW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [2:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // High when the Nios requester wins the next tie.
    logic            rr_nios;
    logic            done_d;
    logic [TW-1:0]   wait_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            tie;
    logic            grant_spi;
    logic            grant_nios;
    logic            grant_any;
    logic [2:0]      grant_dir;
    logic            dir_bad;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            done_rise;
    logic            timed_out;

    always_comb begin
        tie        = spi_req & nios_req;
        grant_spi  = spi_req & (~nios_req | ~rr_nios);
        grant_nios = nios_req & (~spi_req | rr_nios);
        grant_any  = grant_spi | grant_nios;
        grant_dir  = grant_nios ? nios_dir : spi_dir;
        dir_bad    = grant_dir[2];
        fifo_full  = (fifo_count == FULL_LVL);
        push       = grant_any & ~dir_bad & ~fifo_full & ~flush;
        pop        = (state == S_ISSUE) & (fifo_count != '0);
        done_rise  = done_move & ~done_d;
        timed_out  = (state == S_WAIT) & ~done_rise & (wait_cnt == WAIT_LAST);
    end

    always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) begin
            spi_ack  <= 1'b0;
            nios_ack <= 1'b0;
            reject   <= 1'b0;
            drop     <= 1'b0;
            rr_nios  <= 1'b0;
        end else begin
            spi_ack  <= push & grant_spi;
            nios_ack <= push & grant_nios;
            reject   <= grant_any & dir_bad;
            drop     <= tie | (grant_any & ~dir_bad & (fifo_full | flush));
            // A rejected grant leaves the round-robin order untouched.
            if (grant_any & ~dir_bad) begin
                rr_nios <= grant_spi;
            end
        end
    end

    always_ff @(posedge CLK_33) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant_dir;
        end
    end

    always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if ((fifo_count != '0) && !flush) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they align with it.
    always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            done_d      <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            qbert_jump  <= 3'd0;
            start_qbert <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_d      <= done_move;
            start_qbert <= (state_nxt == S_ISSUE);
            busy        <= (state_nxt != S_IDLE);
            wait_cnt    <= (state == S_WAIT) ? (wait_cnt + WAIT_ONE) : '0;
            gap_cnt     <= (state == S_GAP) ? (gap_cnt + GAP_ONE) : '0;
            if ((state == S_IDLE) && (state_nxt == S_ISSUE)) begin
                qbert_jump <= fifo_mem[rd_ptr];
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qbert_jump_scheduler.sv
// Scenario tasks drive the jump scheduler; a scoreboard queue holds the direction
// expected on each start_qbert pulse and a monitor pops it when the pulse appears.
`timescale 1ns/1ps
module tb_qbert_jump_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;

    logic                   CLK_33 = 1'b0;
    logic                   reset;
    logic                   spi_req;
    logic [2:0]             spi_dir;
    logic                   nios_req;
    logic [2:0]             nios_dir;
    logic                   flush;
    logic                   done_move;
    logic                   spi_ack;
    logic                   nios_ack;
    logic                   reject;
    logic                   drop;
    logic [2:0]             qbert_jump;
    logic                   start_qbert;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   timeout_err;

    int         errors    = 0;
    int         checks    = 0;
    int         start_cnt = 0;
    logic [2:0] exp_q[$];

    qbert_jump_scheduler #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .GAP    (GAP)
    ) dut (
        .CLK_33     (CLK_33),
        .reset      (reset),
        .spi_req    (spi_req),
        .spi_dir    (spi_dir),
        .nios_req   (nios_req),
        .nios_dir   (nios_dir),
        .flush      (flush),
        .done_move  (done_move),
        .spi_ack    (spi_ack),
        .nios_ack   (nios_ack),
        .reject     (reject),
        .drop       (drop),
        .qbert_jump (qbert_jump),
        .start_qbert(start_qbert),
        .busy       (busy),
        .fifo_count (fifo_count),
        .timeout_err(timeout_err)
    );

    always #5 CLK_33 = ~CLK_33;

    // Scoreboard: every issue strobe must carry the oldest expected direction.
    always @(negedge CLK_33) begin
        logic [2:0] exp_dir;
        if (start_qbert === 1'b1) begin
            start_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_start: qbert_jump=%0d with nothing expected", qbert_jump);
            end else begin
                exp_dir = exp_q.pop_front();
                if (qbert_jump !== exp_dir) begin
                    errors++;
                    $display("[TB] FAIL issue_dir: got %0d required %0d", qbert_jump, exp_dir);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK_33);
        #1;
    endtask

    task automatic wait_starts(input int n_total);
        for (int i = 0; i < 100 && start_cnt < n_total; i++) step();
        checks++;
        if (start_cnt < n_total) begin
            errors++;
            $display("[TB] FAIL start_wait: starts=%0d required=%0d", start_cnt, n_total);
        end
    endtask

    task automatic run_move(input int n_total);
        wait_starts(n_total);
        step();
        step();
        done_move = 1'b1;
        step();
        done_move = 1'b0;
        repeat (GAP) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spi_req = 1'b0; spi_dir = 3'd0; nios_req = 1'b0; nios_dir = 3'd0;
        flush = 1'b0; done_move = 1'b0;
        step();
        step();
        checks++;
        if ({spi_ack, nios_ack, reject, drop, qbert_jump, start_qbert, busy, timeout_err} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b required 0", {spi_ack, nios_ack, reject, drop, qbert_jump, start_qbert, busy, timeout_err});
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d required 0", fifo_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_tie();
        int base = start_cnt;
        spi_req = 1'b1; spi_dir = 3'd1;
        nios_req = 1'b1; nios_dir = 3'd3;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({spi_ack, nios_ack, drop} !== {(c != 1), (c == 1), 1'b1}) begin
                errors++;
                $display("[TB] FAIL tie_grant cycle %0d: got spi/nios/drop=%b required %b", c, {spi_ack, nios_ack, drop}, {(c != 1), (c == 1), 1'b1});
            end
        end
        spi_req = 1'b0;
        nios_req = 1'b0;
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL tie_count: got %0d required 2", fifo_count);
        end
        run_move(base + 1);
        run_move(base + 2);
        run_move(base + 3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL tie_drain: %0d entries never issued", exp_q.size());
        end
    endtask

    task automatic test_single();
        spi_req = 1'b1; spi_dir = 3'd2;
        exp_q.push_back(3'd2);
        step();
        spi_req = 1'b0;
        checks++;
        if (spi_ack !== 1'b1 || fifo_count !== 3'd1 || start_qbert !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack: got ack=%b count=%0d start=%b required 1/1/0", spi_ack, fifo_count, start_qbert);
        end
        step();
        checks++;
        if (start_qbert !== 1'b1 || qbert_jump !== 3'd2 || spi_ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_issue: got start=%b dir=%0d ack=%b busy=%b required 1/2/0/1", start_qbert, qbert_jump, spi_ack, busy);
        end
        step();
        checks++;
        if (start_qbert !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_wait: got start=%b count=%0d busy=%b required 0/0/1", start_qbert, fifo_count, busy);
        end
        repeat (7) step();
        done_move = 1'b1;
        step();
        done_move = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_gap1: got busy=%b required 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_gap2: got busy=%b required 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_fill_reject();
        int base = start_cnt;
        nios_req = 1'b1; nios_dir = 3'd0;
        exp_q.push_back(3'd0);
        step();
        nios_req = 1'b0;
        wait_starts(base + 1);
        for (int k = 0; k < 4; k++) begin
            nios_req = 1'b1;
            nios_dir = 3'((k + 1) % 4);
            exp_q.push_back(3'((k + 1) % 4));
            step();
            checks++;
            if (nios_ack !== 1'b1 || fifo_count !== 3'(k + 1)) begin
                errors++;
                $display("[TB] FAIL fill_%0d: got ack=%b count=%0d required 1/%0d", k, nios_ack, fifo_count, k + 1);
            end
        end
        nios_dir = 3'd1;
        step();
        nios_req = 1'b0;
        checks++;
        if (nios_ack !== 1'b0 || drop !== 1'b1 || fifo_count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL full_drop: got ack=%b drop=%b count=%0d required 0/1/4", nios_ack, drop, fifo_count);
        end
        spi_req = 1'b1; spi_dir = 3'd5;
        step();
        checks++;
        if (reject !== 1'b1 || spi_ack !== 1'b0 || drop !== 1'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL bad_dir: got reject=%b ack=%b drop=%b count=%0d required 1/0/0/4", reject, spi_ack, drop, fifo_count);
        end
        spi_dir = 3'd7;
        nios_req = 1'b1; nios_dir = 3'd2;
        step();
        spi_req = 1'b0;
        nios_req = 1'b0;
        checks++;
        if (reject !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_after_reject: got reject=%b required 1 (SPI still favoured)", reject);
        end
        for (int m = 1; m <= 5; m++) run_move(base + m);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL fill_drain: %0d entries never issued", exp_q.size());
        end
    endtask

    task automatic test_flush();
        int base = start_cnt;
        nios_req = 1'b1; nios_dir = 3'd3;
        exp_q.push_back(3'd3);
        step();
        nios_req = 1'b0;
        wait_starts(base + 1);
        for (int k = 0; k < 3; k++) begin
            spi_req = 1'b1;
            spi_dir = 3'(k);
            step();
        end
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++;
            $display("[TB] FAIL flush_prefill: got count=%0d required 3", fifo_count);
        end
        spi_dir = 3'd1;
        flush = 1'b1;
        step();
        spi_req = 1'b0;
        flush = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || drop !== 1'b1 || spi_ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_effect: got count=%0d drop=%b ack=%b busy=%b required 0/1/0/1", fifo_count, drop, spi_ack, busy);
        end
        step();
        done_move = 1'b1;
        step();
        done_move = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_inflight: got busy=%b required 1", busy);
        end
        repeat (GAP) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle: got busy=%b required 0", busy);
        end
        repeat (8) step();
        checks++;
        if (start_cnt != base + 1) begin
            errors++;
            $display("[TB] FAIL flush_no_issue: got starts=%0d required %0d", start_cnt, base + 1);
        end
    endtask

    task automatic test_timeout();
        int base = start_cnt;
        spi_req = 1'b1; spi_dir = 3'd1;
        exp_q.push_back(3'd1);
        step();
        spi_dir = 3'd2;
        exp_q.push_back(3'd2);
        step();
        spi_req = 1'b0;
        checks++;
        if (start_qbert !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_first_issue: got start=%b required 1", start_qbert);
        end
        repeat (TIMEOUT) step();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_before: got err=%b busy=%b required 0/1", timeout_err, busy);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_expire: got err=%b busy=%b required 1/0", timeout_err, busy);
        end
        step();
        checks++;
        if (start_qbert !== 1'b1 || qbert_jump !== 3'd2) begin
            errors++;
            $display("[TB] FAIL to_next_issue: got start=%b dir=%0d required 1/2", start_qbert, qbert_jump);
        end
        run_move(base + 2);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_sticky: got err=%b required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        int base = start_cnt;
        nios_req = 1'b1; nios_dir = 3'd1;
        exp_q.push_back(3'd1);
        step();
        nios_dir = 3'd2;
        step();
        nios_dir = 3'd3;
        step();
        nios_req = 1'b0;
        checks++;
        if (fifo_count !== 3'd2 || start_cnt != base + 1) begin
            errors++;
            $display("[TB] FAIL rst_setup: got count=%0d starts=%0d required 2/%0d", fifo_count, start_cnt, base + 1);
        end
        step();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({spi_ack, nios_ack, reject, drop, qbert_jump, start_qbert, busy, timeout_err} !== 10'd0 || fifo_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rst_async: got outs=%b count=%0d required 0/0", {spi_ack, nios_ack, reject, drop, qbert_jump, start_qbert, busy, timeout_err}, fifo_count);
        end
        step();
        #3;
        reset = 1'b0;
        repeat (10) step();
        checks++;
        if (start_cnt != base + 1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rst_quiet: got starts=%0d busy=%b count=%0d required %0d/0/0", start_cnt, busy, fifo_count, base + 1);
        end
        nios_req = 1'b1; nios_dir = 3'd0;
        exp_q.push_back(3'd0);
        step();
        nios_req = 1'b0;
        run_move(base + 2);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_fill_reject();
        test_flush();
        test_timeout();
        test_reset_mid_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_left: %0d entries never issued", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
